// File: rtl/arbitro_pintura.sv
// arbitro_pintura: arbitrates two square-painting requesters (A and B) for a
// single framebuffer write port. The winner's square is latched at grant time
// and raster-scanned (x inner, y outer); each pixel is offered on wr_en/wr_x/
// wr_y/wr_color. Off-screen pixels are clipped: they are never offered but
// still take one SCAN cycle each.
//
// Write handshake: a pixel transfers on a rising edge where wr_en and
// wr_ready are both high. Once wr_en is raised, wr_en, wr_x, wr_y and wr_color
// stay stable until that transfer; wr_ready may be driven freely and has no
// effect while wr_en is low.
//
// The FSM state is exposed on state_dbg (0 = IDLE, 1 = SCAN, 2 = DONE).
module arbitro_pintura #(
    parameter int SCREEN_W = 640,
    parameter int SCREEN_H = 480,
    parameter int COLOR_W  = 8
) (
    input  logic               clock,
    input  logic               reset,
    // Requester A
    input  logic               req_a,
    input  logic [10:0]        x_a,
    input  logic [10:0]        y_a,
    input  logic [6:0]         size_a,
    input  logic [COLOR_W-1:0] color_a,
    output logic               ack_a,
    output logic               done_a,
    // Requester B
    input  logic               req_b,
    input  logic [10:0]        x_b,
    input  logic [10:0]        y_b,
    input  logic [6:0]         size_b,
    input  logic [COLOR_W-1:0] color_b,
    output logic               ack_b,
    output logic               done_b,
    // Framebuffer write port
    output logic               wr_en,
    output logic [10:0]        wr_x,
    output logic [10:0]        wr_y,
    output logic [COLOR_W-1:0] wr_color,
    input  logic               wr_ready,
    // Status
    output logic               busy,
    output logic [1:0]         state_dbg
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_SCAN = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    // Coordinates are carried 12 bits wide so x0+size never wraps; bit 11
    // set (>= 2048) is always off-screen.
    function automatic logic on_screen(input logic [11:0] px, input logic [11:0] py);
        return (px < 12'(SCREEN_W)) && (py < 12'(SCREEN_H));
    endfunction

    // ------------------------------------------------------------------
    // Registered state
    // ------------------------------------------------------------------
    state_t               state_q,  state_n;
    logic                 last_b_q, last_b_n;   // last grant went to B
    logic                 owner_b_q, owner_b_n; // current square belongs to B
    logic [11:0]          x0_q,     x0_n;
    logic [11:0]          y0_q,     y0_n;
    logic [6:0]           size_q,   size_n;
    logic [COLOR_W-1:0]   color_q,  color_n;
    logic [11:0]          cur_x_q,  cur_x_n;
    logic [11:0]          cur_y_q,  cur_y_n;
    logic                 wr_en_q,  wr_en_n;
    logic                 ack_a_q,  ack_a_n;
    logic                 ack_b_q,  ack_b_n;
    logic                 done_a_q, done_a_n;
    logic                 done_b_q, done_b_n;
    logic                 busy_q,   busy_n;

    // ------------------------------------------------------------------
    // Combinational helpers
    // ------------------------------------------------------------------
    logic                 gnt_a;
    logic                 gnt_b;
    logic [11:0]          sel_x;
    logic [11:0]          sel_y;
    logic [6:0]           sel_size;
    logic [COLOR_W-1:0]   sel_color;
    logic [11:0]          x_end;
    logic [11:0]          y_end;
    logic                 advance;
    logic                 last_pixel;
    logic [11:0]          nxt_x;
    logic [11:0]          nxt_y;

    // Arbitration: a lone requester wins; on a tie the side that did not
    // win last time gets the grant.
    always_comb begin
        gnt_a     = 1'b0;
        gnt_b     = 1'b0;
        if (state_q == ST_IDLE) begin
            gnt_a = req_a & (~req_b | last_b_q);
            gnt_b = req_b & (~req_a | ~last_b_q);
        end
        sel_x     = gnt_b ? {1'b0, x_b} : {1'b0, x_a};
        sel_y     = gnt_b ? {1'b0, y_b} : {1'b0, y_a};
        sel_size  = gnt_b ? size_b : size_a;
        sel_color = gnt_b ? color_b : color_a;
    end

    // Raster bookkeeping: square bounds, advance condition and next pixel.
    always_comb begin
        x_end      = x0_q + {5'd0, size_q} - 12'd1;
        y_end      = y0_q + {5'd0, size_q} - 12'd1;
        // Clipped pixels (wr_en low) advance without waiting for wr_ready.
        advance    = ~wr_en_q | wr_ready;
        last_pixel = (cur_x_q == x_end) && (cur_y_q == y_end);
        nxt_x      = cur_x_q + 12'd1;
        nxt_y      = cur_y_q;
        if (cur_x_q == x_end) begin
            nxt_x = x0_q;
            nxt_y = cur_y_q + 12'd1;
        end
    end

    // Next-state and next-output logic for the IDLE/SCAN/DONE controller.
    always_comb begin
        state_n   = state_q;
        last_b_n  = last_b_q;
        owner_b_n = owner_b_q;
        x0_n      = x0_q;
        y0_n      = y0_q;
        size_n    = size_q;
        color_n   = color_q;
        cur_x_n   = cur_x_q;
        cur_y_n   = cur_y_q;
        wr_en_n   = wr_en_q;
        ack_a_n   = 1'b0;
        ack_b_n   = 1'b0;
        done_a_n  = 1'b0;
        done_b_n  = 1'b0;
        busy_n    = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (gnt_a || gnt_b) begin
                    x0_n      = sel_x;
                    y0_n      = sel_y;
                    size_n    = sel_size;
                    color_n   = sel_color;
                    cur_x_n   = sel_x;
                    cur_y_n   = sel_y;
                    last_b_n  = gnt_b;
                    owner_b_n = gnt_b;
                    ack_a_n   = gnt_a;
                    ack_b_n   = gnt_b;
                    if (sel_size == 7'd0) begin
                        // Empty square: nothing to write, finish straight away.
                        state_n = ST_DONE;
                        wr_en_n = 1'b0;
                    end else begin
                        state_n = ST_SCAN;
                        wr_en_n = on_screen(sel_x, sel_y);
                    end
                end
            end

            ST_SCAN: begin
                if (advance) begin
                    if (last_pixel) begin
                        wr_en_n = 1'b0;
                        state_n = ST_DONE;
                    end else begin
                        cur_x_n = nxt_x;
                        cur_y_n = nxt_y;
                        wr_en_n = on_screen(nxt_x, nxt_y);
                    end
                end
            end

            ST_DONE: begin
                state_n = ST_IDLE;
            end

            default: begin
                state_n = ST_IDLE;
                wr_en_n = 1'b0;
            end
        endcase

        // The done pulse is registered so it coincides with the DONE cycle.
        if ((state_n == ST_DONE) && (state_q != ST_DONE)) begin
            done_a_n = ~owner_b_n;
            done_b_n = owner_b_n;
        end
        busy_n = (state_n != ST_IDLE);
    end

    // State and output registers with synchronous reset.
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q   <= ST_IDLE;
            last_b_q  <= 1'b1;
            owner_b_q <= 1'b0;
            x0_q      <= '0;
            y0_q      <= '0;
            size_q    <= '0;
            color_q   <= '0;
            cur_x_q   <= '0;
            cur_y_q   <= '0;
            wr_en_q   <= 1'b0;
            ack_a_q   <= 1'b0;
            ack_b_q   <= 1'b0;
            done_a_q  <= 1'b0;
            done_b_q  <= 1'b0;
            busy_q    <= 1'b0;
        end else begin
            state_q   <= state_n;
            last_b_q  <= last_b_n;
            owner_b_q <= owner_b_n;
            x0_q      <= x0_n;
            y0_q      <= y0_n;
            size_q    <= size_n;
            color_q   <= color_n;
            cur_x_q   <= cur_x_n;
            cur_y_q   <= cur_y_n;
            wr_en_q   <= wr_en_n;
            ack_a_q   <= ack_a_n;
            ack_b_q   <= ack_b_n;
            done_a_q  <= done_a_n;
            done_b_q  <= done_b_n;
            busy_q    <= busy_n;
        end
    end

    assign ack_a     = ack_a_q;
    assign ack_b     = ack_b_q;
    assign done_a    = done_a_q;
    assign done_b    = done_b_q;
    assign wr_en     = wr_en_q;
    assign wr_x      = cur_x_q[10:0];
    assign wr_y      = cur_y_q[10:0];
    assign wr_color  = color_q;
    assign busy      = busy_q;
    assign state_dbg = state_q;

endmodule
